quad_decoder: RTL and testbench

Quadrature encoder decoder with an up/down position counter. It consumes the two-phase A/B output of an incremental encoder and produces a wrapping position count, step/direction strobes and illegal-transition errors. It is the receive side of a step/direction quadrature interface and feeds position to downstream control logic. Inputs are asynchronous to `clk` and are synchronized and glitch-filtered internally.

---
 rtl/quad_decoder.sv | 188 ++++++++++++++++++
 tb/tb_quad_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: synchronizes and glitch-filters the A/B phases,
// decodes Gray-code transitions into up/down steps on a wrapping position
// counter, and flags/counts illegal two-phase transitions.
//
// Handshake: there is no valid/ready pair. step and err are single-cycle
// strobes; count, dir, wrap and err_cnt are registered and valid in the same
// cycle as the strobe that accompanies them.
module quad_decoder #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             qa,
    input  logic             qb,
    input  logic [WIDTH-1:0] load,
    input  logic             load_en,
    input  logic             err_clr,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             wrap,
    output logic             err,
    output logic [7:0]       err_cnt,
    output logic             dbg_run
);

    localparam int CW       = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int INIT_LEN = SYNC_STAGES + 2;
    localparam int ICW      = $clog2(INIT_LEN);

    typedef enum logic {INIT, RUN} state_e;

    state_e           state_q, state_d;
    logic [ICW-1:0]   init_cnt_q, init_cnt_d;
    logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
    logic [1:0]       s;                 // {a, b} after synchronizer
    logic [1:0]       f_q, f_d;          // filtered phases
    logic [CW-1:0]    c_q [2];
    logic [CW-1:0]    c_d [2];
    logic [1:0]       prev_q, prev_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic [1:0] changed;
    logic [1:0] pos_f, pos_p;
    logic       up;
    logic       is_step, is_err;

    assign s = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

    // Synchronizer chains for the asynchronous encoder phases
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
        end else begin
            sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], qa};
            sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], qb};
        end
    end

    // INIT/RUN sequencing: INIT spans INIT_LEN edges so the synchronizers fill
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            INIT: begin
                if (init_cnt_q == ICW'(INIT_LEN - 1)) begin
                    state_d = RUN;
                end else begin
                    init_cnt_d = init_cnt_q + ICW'(1);
                end
            end
            RUN: state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // Per-phase stability filter; INIT copies the synchronized level through
    always_comb begin
        f_d = f_q;
        for (int i = 0; i < 2; i++) begin
            c_d[i] = c_q[i];
            if (state_q == INIT) begin
                f_d[i] = s[i];
                c_d[i] = '0;
            end else if (s[i] != f_q[i]) begin
                if (c_q[i] == CW'(FILTER - 1)) begin
                    f_d[i] = s[i];
                    c_d[i] = '0;
                end else begin
                    c_d[i] = c_q[i] + CW'(1);
                end
            end else begin
                c_d[i] = '0;
            end
        end
    end

    // Gray position 00->0, 01->1, 11->2, 10->3; up is +1 modulo 4
    assign changed = f_q ^ prev_q;
    assign pos_f   = {f_q[1], f_q[1] ^ f_q[0]};
    assign pos_p   = {prev_q[1], prev_q[1] ^ prev_q[0]};
    assign up      = ((pos_f - pos_p) == 2'd1);
    assign is_step = (state_q == RUN) && (changed[1] ^ changed[0]);
    assign is_err  = (state_q == RUN) && (&changed);

    // Step/error decode, position arithmetic and load/clear overrides
    always_comb begin
        prev_d    = f_q;
        count_d   = count_q;
        dir_d     = dir_q;
        step_d    = 1'b0;
        wrap_d    = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        if (is_step) begin
            step_d = 1'b1;
            dir_d  = ~up;
            if (up) begin
                count_d = count_q + WIDTH'(1);
                wrap_d  = &count_q;
            end else begin
                count_d = count_q - WIDTH'(1);
                wrap_d  = (count_q == '0);
            end
        end
        if (is_err) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
        if (load_en) begin
            count_d = load;
            wrap_d  = 1'b0;
        end
        if (err_clr) begin
            err_cnt_d = '0;
        end
    end

    // State, filter and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            f_q        <= '0;
            c_q[0]     <= '0;
            c_q[1]     <= '0;
            prev_q     <= '0;
            count_q    <= '0;
            dir_q      <= 1'b0;
            step_q     <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            f_q        <= f_d;
            c_q[0]     <= c_d[0];
            c_q[1]     <= c_d[1];
            prev_q     <= prev_d;
            count_q    <= count_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign count   = count_q;
    assign dir     = dir_q;
    assign step    = step_q;
    assign wrap    = wrap_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign dbg_run = (state_q == RUN);

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed encoder sequences; every input change that
// should produce a strobe pushes its expected cycle and output snapshot into a
// queue, and a negedge monitor pops and compares on each step/err strobe.
module tb_quad_decoder;

    localparam int WIDTH       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int FILTER      = 3;
    localparam int LAT         = SYNC_STAGES + FILTER + 1;  // drive-to-output edges
    localparam int EW          = 32 + 4 + 8 + WIDTH;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             qa = 1'b0;
    logic             qb = 1'b0;
    logic [WIDTH-1:0] load = '0;
    logic             load_en = 1'b0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] count;
    logic             dir, step, wrap, err, dbg_run;
    logic [7:0]       err_cnt;

    logic [31:0]   cyc = 32'd0;
    logic [EW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_fail = 0;

    quad_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .FILTER(FILTER)) dut (
        .clk(clk), .rstn(rstn), .qa(qa), .qb(qb), .load(load), .load_en(load_en),
        .err_clr(err_clr), .count(count), .dir(dir), .step(step), .wrap(wrap),
        .err(err), .err_cnt(err_cnt), .dbg_run(dbg_run)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a phase change and queue the strobe it should produce.
    // side: 0 none, 1 pulse load_en at the output edge, 2 pulse err_clr there.
    task automatic apply(input logic a, input logic b, input logic e_step, input logic e_err,
                         input logic e_wrap, input logic e_dir, input logic [7:0] e_ec,
                         input logic [WIDTH-1:0] e_cnt, input int side, input int hold);
        qa = a;
        qb = b;
        exp_q.push_back({cyc + 32'(LAT), e_step, e_err, e_wrap, e_dir, e_ec, e_cnt});
        if (side == 0) begin
            repeat (hold) tick();
        end else begin
            repeat (LAT - 1) tick();
            if (side == 1) load_en = 1'b1;
            else           err_clr = 1'b1;
            tick();
            load_en = 1'b0;
            err_clr = 1'b0;
            repeat (hold - LAT) tick();
        end
    endtask

    // Scoreboard monitor: every strobe must match the head of the queue
    always @(negedge clk) begin
        if (step || err) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: got step=%b err=%b count=%h at cycle %0d expected none",
                         step, err, count, cyc);
            end else begin
                logic [EW-1:0] e, a;
                e = exp_q.pop_front();
                a = {cyc, step, err, wrap, dir, err_cnt, count};
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL strobe: got cyc=%0d s/e/w/d=%b ec=%h cnt=%h expected cyc=%0d s/e/w/d=%b ec=%h cnt=%h",
                             a[EW-1 -: 32], a[EW-33 -: 4], a[WIDTH+7 -: 8], a[WIDTH-1:0],
                             e[EW-1 -: 32], e[EW-33 -: 4], e[WIDTH+7 -: 8], e[WIDTH-1:0]);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_count"},   32'(count),   32'h0);
        check({tag, "_dir"},     32'(dir),     32'h0);
        check({tag, "_step"},    32'(step),    32'h0);
        check({tag, "_wrap"},    32'(wrap),    32'h0);
        check({tag, "_err"},     32'(err),     32'h0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'h0);
    endtask

    initial begin
        // Reset and INIT
        repeat (3) tick();
        check_all_zero("reset");
        check("reset_init", 32'(dbg_run), 32'h0);
        rstn = 1'b1;
        repeat (8) tick();
        check("run_entered", 32'(dbg_run), 32'h1);

        // Four forward transitions
        apply(1'b0, 1'b1, 1, 0, 0, 0, 8'd0, 16'd1, 0, 8);
        apply(1'b1, 1'b1, 1, 0, 0, 0, 8'd0, 16'd2, 0, 8);
        apply(1'b1, 1'b0, 1, 0, 0, 0, 8'd0, 16'd3, 0, 8);
        apply(1'b0, 1'b0, 1, 0, 0, 0, 8'd0, 16'd4, 0, 8);
        check("fwd_count", 32'(count), 32'd4);
        check("fwd_dir",   32'(dir),   32'd0);

        // Load 0, wrap down then wrap up
        load = 16'h0000;
        load_en = 1'b1;
        tick();
        load_en = 1'b0;
        tick();
        check("load_zero", 32'(count), 32'h0);
        apply(1'b1, 1'b0, 1, 0, 1, 1, 8'd0, 16'hFFFF, 0, 8);
        apply(1'b0, 1'b0, 1, 0, 1, 0, 8'd0, 16'h0000, 0, 8);

        // Glitches shorter than FILTER are rejected, a held change counts once
        apply(1'b0, 1'b1, 1, 0, 0, 0, 8'd0, 16'd1, 0, 8);
        qa = 1'b1; tick(); qa = 1'b0;
        repeat (8) tick();
        qa = 1'b1; repeat (2) tick(); qa = 1'b0;
        repeat (10) tick();
        check("glitch_count", 32'(count), 32'd1);
        apply(1'b1, 1'b1, 1, 0, 0, 0, 8'd0, 16'd2, 0, 8);

        // Illegal transitions, saturation and clear priority
        for (int i = 0; i < 300; i++) begin
            logic lv;
            lv = (i % 2 == 0) ? 1'b0 : 1'b1;
            apply(lv, lv, 0, 1, 0, 0, (i + 1 > 255) ? 8'd255 : 8'(i + 1), 16'd2, 0, 5);
        end
        repeat (3) tick();
        check("err_sat", 32'(err_cnt), 32'd255);
        check("err_count_kept", 32'(count), 32'd2);
        apply(1'b0, 1'b0, 0, 1, 0, 0, 8'd0, 16'd2, 2, 8);
        check("err_clr", 32'(err_cnt), 32'd0);

        // Load coincident with an up step
        load = 16'h1234;
        apply(1'b0, 1'b1, 1, 0, 0, 0, 8'd0, 16'h1234, 1, 8);
        check("load_step_count", 32'(count), 32'h1234);

        // Reset mid-sequence with inputs held at 11
        apply(1'b1, 1'b1, 1, 0, 0, 0, 8'd0, 16'h1235, 0, 8);
        rstn = 1'b0;
        #2;
        check_all_zero("async_reset");
        check("async_reset_init", 32'(dbg_run), 32'h0);
        repeat (3) tick();
        rstn = 1'b1;
        repeat (10) tick();
        check_all_zero("post_init");
        check("post_init_run", 32'(dbg_run), 32'h1);
        apply(1'b1, 1'b0, 1, 0, 0, 0, 8'd0, 16'd1, 0, 8);
        check("post_reset_count", 32'(count), 32'd1);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
